// File: rtl/irq_ack_dec_8_if.sv
// ----------------------------------------------------------------------------
// irq_ack_dec_8_if
//   Groups the code handshake, the live request lines and the acknowledge
//   outputs of irq_ack_dec_8. Clock and reset are not part of the bundle.
//
//   code_valid  CPU -> dec   code presented this cycle
//   code        CPU -> dec   0 = none, 1..8 = line 0..7, 9..15 illegal
//   code_ready  dec -> CPU   decoder can take a code (IDLE only)
//   req         src -> dec   live request lines (same lines the encoder sees)
//   ack         dec -> src   one-hot acknowledge, zero when idle
//   busy        dec -> CPU   an ack is currently held
//   code_err    dec -> CPU   one-cycle pulse, illegal code accepted
//   timeout_err dec -> CPU   one-cycle pulse, ack released by timeout
//
//   master: the CPU/request side that drives code and req.
//   slave : the decoder.
// ----------------------------------------------------------------------------
interface irq_ack_dec_8_if;
  logic       code_valid;
  logic [3:0] code;
  logic       code_ready;
  logic [7:0] req;
  logic [7:0] ack;
  logic       busy;
  logic       code_err;
  logic       timeout_err;

  modport master (
    output code_valid,
    output code,
    output req,
    input  code_ready,
    input  ack,
    input  busy,
    input  code_err,
    input  timeout_err
  );

  modport slave (
    input  code_valid,
    input  code,
    input  req,
    output code_ready,
    output ack,
    output busy,
    output code_err,
    output timeout_err
  );
endinterface

// File: rtl/irq_ack_dec_8.sv
// ----------------------------------------------------------------------------
// irq_ack_dec_8
//   Acknowledge-side partner of the 8-input priority encoder. Accepts an
//   encoded line number (0 = none, 1..8 = line 0..7) over a valid/ready
//   handshake and drives a one-hot ack on that line. The ack is held until the
//   acknowledged request drops or until TIMEOUT_CYCLES cycles have elapsed
//   with the request still high.
//
//   Ports
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     bus     irq_ack_dec_8_if.slave: code_valid/code/code_ready handshake,
//             req lines in, ack/busy/code_err/timeout_err out
//
//   Parameters
//     TIMEOUT_CYCLES  maximum ack length in cycles, 1 .. 2**CNT_W-1
//     CNT_W           width of the timeout counter
//
//   Every output is either a register or a decode of the state register, so
//   there is no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module irq_ack_dec_8 #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  irq_ack_dec_8_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Counter value at which the ack is released if the request is still high.
  // The counter starts at 0 on the accept edge, so the ack can be seen on at
  // most TIMEOUT_CYCLES edges while in ACK.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [7:0]       ack_reg;
  logic [2:0]       idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             code_err_reg;
  logic             timeout_err_reg;

  // Decode of the incoming code, only consulted on an accepting edge.
  logic [7:0] code_onehot;
  logic [2:0] code_idx;
  logic       code_legal;
  logic       code_illegal;
  logic       held_req;

  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign code_onehot[gi] = (bus.code == 4'(gi + 1));
  end

  // Wraps for code 0, but the index is only latched for codes 1..8.
  assign code_idx     = 3'(bus.code - 4'd1);
  assign code_legal   = (bus.code != 4'd0) && (bus.code <= 4'd8);
  assign code_illegal = (bus.code > 4'd8);
  assign held_req     = bus.req[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      ack_reg         <= 8'h00;
      idx_reg         <= 3'd0;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      code_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses by default.
      code_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (bus.code_valid) begin
            if (code_legal) begin
              ack_reg   <= code_onehot;
              idx_reg   <= code_idx;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
              state_reg <= ST_ACK;
            end else if (code_illegal) begin
              code_err_reg <= 1'b1;
            end
            // code 0: a "nothing pending" answer, silently consumed
          end
        end

        ST_ACK: begin
          // Request drop is tested first so it beats a coincident timeout.
          if (!held_req) begin
            ack_reg   <= 8'h00;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            ack_reg         <= 8'h00;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: begin
          ack_reg   <= 8'h00;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // code_ready is a pure state decode; no code is taken on the edge that
  // releases an ack, which guarantees one idle cycle between acks.
  assign bus.code_ready  = (state_reg == ST_IDLE);
  assign bus.ack         = ack_reg;
  assign bus.busy        = busy_reg;
  assign bus.code_err    = code_err_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_irq_ack_dec_8.sv
// ----------------------------------------------------------------------------
// tb_irq_ack_dec_8
//   Directed and randomized transactions for irq_ack_dec_8. Each transaction
//   is described by its code and by d, the number of edges after acceptance
//   at which the acknowledged request is first seen low. Expected behaviour
//   follows from plain arithmetic: ack lasts min(d, T) cycles and a timeout
//   is reported exactly when d > T.
// ----------------------------------------------------------------------------
module tb_irq_ack_dec_8;

  localparam int T = 15;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  irq_ack_dec_8_if bus ();

  irq_ack_dec_8 #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random activity on every line, then the acknowledged line forced.
  task automatic drive_req(input int idx, input bit force_line, input bit val);
    bus.req = 8'($urandom);
    if (force_line) bus.req[idx] = val;
  endtask

  // One complete transaction from IDLE back to IDLE.
  task automatic run_txn(input logic [3:0] c, input int d);
    bit         legal;
    int         idx;
    int         n;
    bit         to;
    logic [7:0] exp_ack;
    legal   = (c >= 4'd1) && (c <= 4'd8);
    idx     = legal ? int'(c) - 1 : 0;
    exp_ack = legal ? (8'h01 << idx) : 8'h00;
    n       = (d < T) ? d : T;
    to      = (d > T);
    $display("txn code=%0d drop_at=%0d exp_len=%0d exp_timeout=%0d", c, d, legal ? n : 0, legal && to);
    chk("ready_before_txn", bus.code_ready, 1'b1);
    bus.code       = c;
    bus.code_valid = 1'b1;
    drive_req(idx, legal, d > 1);
    tick();
    bus.code_valid = 1'b0;
    if (!legal) begin
      chk("code_err_pulse", bus.code_err, c >= 4'd9);
      chk("ack_after_nonlegal", bus.ack, 8'h00);
      chk("ready_after_nonlegal", bus.code_ready, 1'b1);
      tick();
      chk("code_err_cleared", bus.code_err, 1'b0);
      chk("ready_still_high", bus.code_ready, 1'b1);
      return;
    end
    chk("ack_first_cycle", bus.ack, exp_ack);
    chk("busy_first_cycle", bus.busy, 1'b1);
    chk("ready_low_in_ack", bus.code_ready, 1'b0);
    chk("no_code_err_legal", bus.code_err, 1'b0);
    for (int k = 1; k <= n; k++) begin
      drive_req(idx, 1'b1, k < d);
      tick();
      if (k < n) begin
        chk("ack_held", bus.ack, exp_ack);
        chk("no_early_timeout", bus.timeout_err, 1'b0);
      end else begin
        chk("ack_released", bus.ack, 8'h00);
        chk("busy_released", bus.busy, 1'b0);
        chk("ready_after_release", bus.code_ready, 1'b1);
        chk("timeout_err_at_release", bus.timeout_err, to);
      end
    end
    tick();
    chk("timeout_err_one_cycle", bus.timeout_err, 1'b0);
    chk("ack_idle", bus.ack, 8'h00);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    bus.code_valid = 1'b0;
    bus.code       = 4'd0;
    bus.req        = 8'h00;
    rst_n          = 1'b0;

    // Reset values, before any clock edge
    #1;
    chk("rst_ack", bus.ack, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.code_ready, 1'b1);
    chk("rst_code_err", bus.code_err, 1'b0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Scenario 1: code 3, request drops 4 cycles after accept
    run_txn(4'd3, 4);
    // Scenario 2: code 8, request never drops -> timeout after T cycles
    run_txn(4'd8, 100);
    // Scenario 3: code 0 then code 12
    run_txn(4'd0, 1);
    run_txn(4'd12, 1);
    // Scenario 4: request drops on the edge the counter reaches T-1
    run_txn(4'd1, T);
    // Request already low at accept: ack still lasts one cycle
    run_txn(4'd4, 1);
    // Request drops one edge after the timeout would fire
    run_txn(4'd2, T + 1);

    // Scenario 5: code 1 then code 2 with code_valid held high
    $display("txn back_to_back code=1 then code=2");
    bus.req        = 8'h01;
    bus.code       = 4'd1;
    bus.code_valid = 1'b1;
    tick();
    chk("b2b_ack1", bus.ack, 8'h01);
    bus.code = 4'd2;
    for (int k = 0; k < 3; k++) begin
      bus.req = (k % 2 == 0) ? 8'h03 : 8'h01;
      tick();
      chk("b2b_ack1_held", bus.ack, 8'h01);
      chk("b2b_ready_low", bus.code_ready, 1'b0);
    end
    bus.req = 8'h02;
    tick();
    chk("b2b_idle_gap_ack", bus.ack, 8'h00);
    chk("b2b_idle_gap_ready", bus.code_ready, 1'b1);
    tick();
    chk("b2b_ack2", bus.ack, 8'h02);
    bus.code_valid = 1'b0;
    bus.req        = 8'h00;
    tick();
    chk("b2b_ack2_released", bus.ack, 8'h00);
    chk("b2b_no_timeout", bus.timeout_err, 1'b0);
    tick();

    // Scenario 6: asynchronous reset in the middle of an ack on line 4
    $display("txn reset_mid_ack code=5");
    bus.req        = 8'h10;
    bus.code       = 4'd5;
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    chk("rst6_ack_before", bus.ack, 8'h10);
    tick();
    chk("rst6_ack_still", bus.ack, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst6_ack_async", bus.ack, 8'h00);
    chk("rst6_busy_async", bus.busy, 1'b0);
    chk("rst6_ready_async", bus.code_ready, 1'b1);
    chk("rst6_no_code_err", bus.code_err, 1'b0);
    chk("rst6_no_timeout", bus.timeout_err, 1'b0);
    bus.req        = 8'h20;
    bus.code       = 4'd6;
    bus.code_valid = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst6_accept_after_release", bus.ack, 8'h20);
    bus.code_valid = 1'b0;
    bus.req        = 8'h00;
    tick();
    chk("rst6_release", bus.ack, 8'h00);
    tick();

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rc;
      int         rd;
      rc = 4'($urandom_range(0, 15));
      rd = int'($urandom_range(1, T + 5));
      run_txn(rc, rd);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
